mbtrain_seq_param: RTL and testbench

//  Parametrised MBTRAIN sequencer for the logphy LTSM, at 100 MHz. Sits between LTSM top, sideband
//  TX/RX message path and mainband pattern generator/checker. Walks the enabled MBTRAIN substates

---
 rtl/mbtrain_seq_param_pkg.sv | 62 ++++++
 rtl/mbtrain_seq_param_timeout_ctr.sv | 17 +
 rtl/mbtrain_seq_param.sv | 102 ++++++++++
 tb/tb_mbtrain_seq_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mbtrain_seq_param_pkg.sv
// mbtrain_seq_param_pkg: sideband message codes, substate enum and code helpers
package mbtrain_seq_param_pkg;
  typedef enum logic [7:0] {
    SB_NONE                            = 8'h00,
    MBTRAIN_VALVREF_START_REQ          = 8'h20,
    MBTRAIN_VALVREF_START_RESP         = 8'h21,
    MBTRAIN_VALVREF_END_REQ            = 8'h22,
    MBTRAIN_VALVREF_END_RESP           = 8'h23,
    MBTRAIN_DATAVREF_START_REQ         = 8'h24,
    MBTRAIN_DATAVREF_START_RESP        = 8'h25,
    MBTRAIN_DATAVREF_END_REQ           = 8'h26,
    MBTRAIN_DATAVREF_END_RESP          = 8'h27,
    MBTRAIN_SPEEDIDLE_START_REQ        = 8'h28,
    MBTRAIN_SPEEDIDLE_START_RESP       = 8'h29,
    MBTRAIN_SPEEDIDLE_END_REQ          = 8'h2A,
    MBTRAIN_SPEEDIDLE_END_RESP         = 8'h2B,
    MBTRAIN_TXSELFCAL_START_REQ        = 8'h2C,
    MBTRAIN_TXSELFCAL_START_RESP       = 8'h2D,
    MBTRAIN_TXSELFCAL_END_REQ          = 8'h2E,
    MBTRAIN_TXSELFCAL_END_RESP         = 8'h2F,
    MBTRAIN_RXCLKCAL_START_REQ         = 8'h30,
    MBTRAIN_RXCLKCAL_START_RESP        = 8'h31,
    MBTRAIN_RXCLKCAL_END_REQ           = 8'h32,
    MBTRAIN_RXCLKCAL_END_RESP          = 8'h33,
    MBTRAIN_VALTRAINCENTER_START_REQ   = 8'h34,
    MBTRAIN_VALTRAINCENTER_START_RESP  = 8'h35,
    MBTRAIN_VALTRAINCENTER_END_REQ     = 8'h36,
    MBTRAIN_VALTRAINCENTER_END_RESP    = 8'h37,
    MBTRAIN_DATATRAINCENTER_START_REQ  = 8'h38,
    MBTRAIN_DATATRAINCENTER_START_RESP = 8'h39,
    MBTRAIN_DATATRAINCENTER_END_REQ    = 8'h3A,
    MBTRAIN_DATATRAINCENTER_END_RESP   = 8'h3B,
    MBTRAIN_LINKSPEED_START_REQ        = 8'h3C,
    MBTRAIN_LINKSPEED_START_RESP       = 8'h3D,
    MBTRAIN_LINKSPEED_END_REQ          = 8'h3E,
    MBTRAIN_LINKSPEED_END_RESP         = 8'h3F
  } SB_msg_t;
  typedef enum logic [2:0] {
    SUB_VALVREF, SUB_DATAVREF, SUB_SPEEDIDLE, SUB_TXSELFCAL,
    SUB_RXCLKCAL, SUB_VALTRAINCENTER, SUB_DATATRAINCENTER, SUB_LINKSPEED
  } mbtrain_sub_e;
  localparam logic [1:0] K_START_REQ = 2'd0;
  localparam logic [1:0] K_START_RESP = 2'd1;
  localparam logic [1:0] K_END_REQ = 2'd2;
  localparam logic [1:0] K_END_RESP = 2'd3;
  // Codes are laid out as 001_sub_kind so they can be built arithmetically
  function automatic SB_msg_t mb_msg(input mbtrain_sub_e sub, input logic [1:0] kind);
    return SB_msg_t'({3'b001, sub, kind});
  endfunction
  function automatic logic [2:0] first_en(input logic [7:0] mask);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) if (mask[i]) r = 3'(i);
    return r;
  endfunction
  function automatic logic [3:0] next_en(input logic [7:0] mask, input logic [2:0] cur);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) if (mask[i] && 3'(i) > cur) r = {1'b1, 3'(i)};
    return r;
  endfunction
endpackage

// File: rtl/mbtrain_seq_param_timeout_ctr.sv
// mbtrain_timeout_ctr: wait-state cycle counter that flags the last allowed cycle
module mbtrain_timeout_ctr #(
  parameter int WIDTH = 20,
  parameter int LIMIT = 800000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired_o
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
  logic [WIDTH-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || clear) ? '0 : count_en ? r_cnt + 1'b1 : r_cnt;
  assign expired_o = count_en && r_cnt == LAST;
endmodule

// File: rtl/mbtrain_seq_param.sv
// mbtrain_seq_param: MBTRAIN substate walker with SB handshakes, timeout, retry and lane degrade
module mbtrain_seq_param
  import mbtrain_seq_param_pkg::*;
#(
  parameter int         LANES       = 16,
  parameter logic [7:0] SUB_EN_MASK = 8'hFF,
  parameter int         TIMEOUT_CYC = 800000,
  parameter int         MAX_RETRY   = 2,
  parameter bit         DEGRADE_EN  = 1'b1
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             enable_i,
  output SB_msg_t          TX_msg_o,
  output logic             TX_msg_valid_o,
  input  SB_msg_t          RX_msg_i,
  input  logic             RX_msg_valid_i,
  output logic             RX_msg_req_o,
  output logic             pattern_start_o,
  input  logic             lane_result_valid_i,
  input  logic [LANES-1:0] lane_err_i,
  output logic [LANES-1:0] lane_en_o,
  output logic [2:0]       substate_o,
  output logic [1:0]       retry_cnt_o,
  output logic             MBTRAIN_done_o,
  output logic             MBTRAIN_fail_o
);
  typedef enum logic [3:0] {
    S_IDLE, S_SEND_START, S_WAIT_START, S_RUN_PAT, S_WAIT_PAT,
    S_SEND_END, S_WAIT_END, S_EVAL, S_DONE, S_FAIL
  } mbtrain_state_e;
  localparam int H = LANES / 2;
  localparam logic [LANES-1:0] LO_MASK = {{H{1'b0}}, {H{1'b1}}};
  localparam logic [LANES-1:0] HI_MASK = {{H{1'b1}}, {H{1'b0}}};
  localparam logic [1:0] MAX_R = 2'(MAX_RETRY);
  localparam mbtrain_sub_e FIRST = mbtrain_sub_e'(first_en(SUB_EN_MASK));
  mbtrain_state_e r_state, w_state_nx;
  mbtrain_sub_e r_sub;
  logic [LANES-1:0] r_err, r_lane_en;
  logic [1:0] r_retry;
  SB_msg_t r_tx_last, w_exp_msg;
  logic w_in_wait, w_expired, w_rx_hit, w_err_lo, w_err_hi, w_degrade, w_retry;
  logic [3:0] w_nxt;
  assign w_in_wait = r_state == S_WAIT_START || r_state == S_WAIT_PAT || r_state == S_WAIT_END;
  assign w_exp_msg = mb_msg(r_sub, r_state == S_WAIT_START ? K_START_RESP : K_END_RESP);
  assign w_rx_hit = RX_msg_req_o && RX_msg_valid_i && RX_msg_i == w_exp_msg;
  assign w_nxt = next_en(SUB_EN_MASK, r_sub);
  assign w_err_lo = r_err[H-1:0] != '0;
  assign w_err_hi = r_err[LANES-1:H] != '0;
  // Degrade only from the full map and only when exactly one half saw errors
  assign w_degrade = DEGRADE_EN && (&r_lane_en) && (w_err_lo ^ w_err_hi);
  assign w_retry = r_state == S_EVAL && w_state_nx == S_SEND_START;
  mbtrain_timeout_ctr #(.WIDTH($clog2(TIMEOUT_CYC + 1)), .LIMIT(TIMEOUT_CYC)) u_tmo (
    .clk(clk_100MHz), .rst(reset), .clear(!w_in_wait), .count_en(w_in_wait), .expired_o(w_expired)
  );
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:       w_state_nx = S_SEND_START;
      S_SEND_START: w_state_nx = S_WAIT_START;
      S_WAIT_START: w_state_nx = w_rx_hit ? S_RUN_PAT : w_expired ? S_FAIL : S_WAIT_START;
      S_RUN_PAT:    w_state_nx = S_WAIT_PAT;
      S_WAIT_PAT:   w_state_nx = lane_result_valid_i ? S_SEND_END : w_expired ? S_FAIL : S_WAIT_PAT;
      S_SEND_END:   w_state_nx = S_WAIT_END;
      S_WAIT_END:   w_state_nx = w_rx_hit ? (w_nxt[3] ? S_SEND_START : S_EVAL)
                                          : w_expired ? S_FAIL : S_WAIT_END;
      S_EVAL:       w_state_nx = (r_err == '0 || w_degrade) ? S_DONE
                                 : r_retry < MAX_R ? S_SEND_START : S_FAIL;
      default:      w_state_nx = r_state;
    endcase
    if (!enable_i) w_state_nx = S_IDLE;
  end
  always_ff @(posedge clk_100MHz) begin
    if (reset || !enable_i) begin
      r_state   <= S_IDLE;
      r_sub     <= SUB_VALVREF;
      r_err     <= '0;
      r_retry   <= '0;
      r_lane_en <= '1;
      r_tx_last <= SB_NONE;
    end else begin
      r_state   <= w_state_nx;
      r_tx_last <= TX_msg_o;
      if (r_state == S_IDLE || w_retry) r_sub <= FIRST;
      else if (r_state == S_WAIT_END && w_rx_hit && w_nxt[3]) r_sub <= mbtrain_sub_e'(w_nxt[2:0]);
      if (r_state == S_WAIT_PAT && lane_result_valid_i) r_err <= r_err | (lane_err_i & r_lane_en);
      else if (w_retry) r_err <= '0;
      if (w_retry) r_retry <= r_retry + 2'd1;
      if (r_state == S_EVAL && r_err != '0 && w_degrade) r_lane_en <= w_err_hi ? LO_MASK : HI_MASK;
    end
  end
  assign TX_msg_valid_o = r_state == S_SEND_START || r_state == S_SEND_END;
  assign TX_msg_o = r_state == S_SEND_START ? mb_msg(r_sub, K_START_REQ)
                  : r_state == S_SEND_END ? mb_msg(r_sub, K_END_REQ) : r_tx_last;
  assign RX_msg_req_o = r_state == S_WAIT_START || r_state == S_WAIT_END;
  assign pattern_start_o = r_state == S_RUN_PAT;
  assign lane_en_o = r_lane_en;
  assign substate_o = r_sub;
  assign retry_cnt_o = r_retry;
  assign MBTRAIN_done_o = r_state == S_DONE;
  assign MBTRAIN_fail_o = r_state == S_FAIL;
endmodule

// File: tb/tb_mbtrain_seq_param.sv
// tb_mbtrain_seq_param: vector table plus scoreboarded TX stream and hand-written corner sequences
module tb_mbtrain_seq_param;
  import mbtrain_seq_param_pkg::*;
  logic clk = 0, rst = 1, en_a = 0, en_b = 0, sel = 0;
  logic rx_v = 0, res_v = 0;
  SB_msg_t rx_msg = SB_NONE;
  logic [15:0] lane_err = '0;
  SB_msg_t tx_a, tx_b;
  logic tx_v_a, tx_v_b, req_a, req_b, pat_a, pat_b, done_a, done_b, fail_a, fail_b;
  logic [15:0] lane_a, lane_b;
  logic [2:0] sub_a, sub_b;
  logic [1:0] retry_a, retry_b;
  always #5 clk = ~clk;
  mbtrain_seq_param #(.SUB_EN_MASK(8'hFF), .TIMEOUT_CYC(100)) dut_a (
    .clk_100MHz(clk), .reset(rst), .enable_i(en_a), .TX_msg_o(tx_a), .TX_msg_valid_o(tx_v_a),
    .RX_msg_i(rx_msg), .RX_msg_valid_i(rx_v), .RX_msg_req_o(req_a), .pattern_start_o(pat_a),
    .lane_result_valid_i(res_v), .lane_err_i(lane_err), .lane_en_o(lane_a), .substate_o(sub_a),
    .retry_cnt_o(retry_a), .MBTRAIN_done_o(done_a), .MBTRAIN_fail_o(fail_a));
  mbtrain_seq_param #(.SUB_EN_MASK(8'h81), .TIMEOUT_CYC(100)) dut_b (
    .clk_100MHz(clk), .reset(rst), .enable_i(en_b), .TX_msg_o(tx_b), .TX_msg_valid_o(tx_v_b),
    .RX_msg_i(rx_msg), .RX_msg_valid_i(rx_v), .RX_msg_req_o(req_b), .pattern_start_o(pat_b),
    .lane_result_valid_i(res_v), .lane_err_i(lane_err), .lane_en_o(lane_b), .substate_o(sub_b),
    .retry_cnt_o(retry_b), .MBTRAIN_done_o(done_b), .MBTRAIN_fail_o(fail_b));
  logic [7:0] m_tx;
  logic m_tx_v, m_req, m_pat, m_done, m_fail;
  logic [15:0] m_lane;
  logic [2:0] m_sub;
  logic [1:0] m_retry;
  assign m_tx = sel ? tx_b : tx_a;
  assign m_tx_v = sel ? tx_v_b : tx_v_a;
  assign m_req = sel ? req_b : req_a;
  assign m_pat = sel ? pat_b : pat_a;
  assign m_done = sel ? done_b : done_a;
  assign m_fail = sel ? fail_b : fail_a;
  assign m_lane = sel ? lane_b : lane_a;
  assign m_sub = sel ? sub_b : sub_a;
  assign m_retry = sel ? retry_b : retry_a;
  typedef struct {
    bit sel; logic [15:0] err_all; logic [15:0] err_link; bit wrong; int passes;
    logic done; logic fail; logic [1:0] retry; logic [15:0] lane;
  } vec_t;
  vec_t vecs[7];
  int total = 0, bad = 0;
  logic [7:0] exp_q[$];
  logic [15:0] err_all = '0, err_link = '0;
  bit sb_on = 0, skip_start = 0, wrong_end = 0, wr_chk = 0;
  int rsp_cnt = 0, wr_cnt = 0, pat_cnt = 0;
  logic [7:0] rsp_code, wr_code;
  logic [2:0] pat_sub, wr_sub;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] code(input int s, input int k);
    return 8'(32'h20 + 4 * s + k);
  endfunction
  task automatic clear_pend();
    rsp_cnt = 0; wr_cnt = 0; pat_cnt = 0; wr_chk = 0;
  endtask
  // One negedge of the responder: drive due pulses, score TX, schedule replies
  task automatic step();
    @(negedge clk);
    rx_v = 0; res_v = 0;
    if (wr_chk) begin
      chk("wrong_ignored", 32'({m_req, m_sub}), 32'({1'b1, wr_sub}));
      wr_chk = 0;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin rx_msg = SB_msg_t'(rsp_code); rx_v = 1; end
    end
    if (wr_cnt > 0) begin
      wr_cnt--;
      if (wr_cnt == 0) begin rx_msg = SB_msg_t'(wr_code); rx_v = 1; wr_chk = 1; end
    end
    if (pat_cnt > 0) begin
      pat_cnt--;
      if (pat_cnt == 0) begin res_v = 1; lane_err = pat_sub == 3'd7 ? err_link : err_all; end
    end
    if (m_tx_v) begin
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_extra: got %0h expected no pulse", m_tx);
        end else chk("tx_code", 32'(m_tx), 32'(exp_q.pop_front()));
      end
      if (m_tx[1:0] == 2'd0 && !skip_start) begin rsp_code = m_tx + 8'd1; rsp_cnt = 3; end
      if (m_tx[1:0] == 2'd2) begin
        rsp_code = m_tx + 8'd1;
        rsp_cnt = wrong_end ? 5 : 3;
        if (wrong_end) begin wr_code = m_tx - 8'd1; wr_cnt = 2; wr_sub = m_sub; end
      end
    end
    if (m_pat) begin pat_cnt = 3; pat_sub = m_sub; end
  endtask
  task automatic push_pass(input logic [7:0] mask);
    for (int s = 0; s < 8; s++) if (mask[s]) begin
      exp_q.push_back(code(s, 0));
      exp_q.push_back(code(s, 2));
    end
  endtask
  task automatic set_en(input logic v);
    if (sel) en_b = v; else en_a = v;
  endtask
  task automatic wait_end(input string name, output int n);
    n = 0;
    while (!(m_done || m_fail) && n < 5000) begin step(); n++; end
    chk(name, 32'(n < 5000), 32'd1);
  endtask
  task automatic stop_idle(input string name);
    set_en(0); clear_pend();
    step(); step();
    chk(name, 32'({m_done, m_fail, m_req, m_tx_v, m_pat, m_tx, m_lane, m_sub, m_retry}),
        32'({5'b0, 8'h00, 16'hFFFF, 3'd0, 2'd0}));
    exp_q.delete();
  endtask
  initial begin
    int n;
    vecs[0] = '{0, 16'h0000, 16'h0000, 0, 1, 1, 0, 2'd0, 16'hFFFF};
    vecs[1] = '{1, 16'h0000, 16'h0100, 0, 1, 1, 0, 2'd0, 16'h00FF};
    vecs[2] = '{0, 16'h0101, 16'h0101, 0, 3, 0, 1, 2'd2, 16'hFFFF};
    vecs[3] = '{0, 16'h00F0, 16'h0000, 0, 1, 1, 0, 2'd0, 16'hFF00};
    vecs[4] = '{0, 16'h0000, 16'h8000, 0, 1, 1, 0, 2'd0, 16'h00FF};
    vecs[5] = '{1, 16'h0001, 16'h8000, 0, 3, 0, 1, 2'd2, 16'hFFFF};
    vecs[6] = '{0, 16'h0000, 16'h0000, 1, 1, 1, 0, 2'd0, 16'hFFFF};
    repeat (3) step();
    rst = 0;
    step();
    chk("reset_a", 32'({done_a, fail_a, req_a, tx_v_a, pat_a, tx_a, lane_a, sub_a, retry_a}),
        32'({5'b0, 8'h00, 16'hFFFF, 3'd0, 2'd0}));
    chk("reset_b", 32'({done_b, fail_b, tx_b, lane_b}), 32'({2'b0, 8'h00, 16'hFFFF}));
    for (int i = 0; i < 7; i++) begin
      sel = vecs[i].sel; err_all = vecs[i].err_all; err_link = vecs[i].err_link;
      wrong_end = vecs[i].wrong; sb_on = 1;
      for (int p = 0; p < vecs[i].passes; p++) push_pass(sel ? 8'h81 : 8'hFF);
      set_en(1);
      wait_end($sformatf("v%0d_finish", i), n);
      chk($sformatf("v%0d_done_fail", i), 32'({m_done, m_fail}), 32'({vecs[i].done, vecs[i].fail}));
      chk($sformatf("v%0d_lane_en", i), 32'(m_lane), 32'(vecs[i].lane));
      chk($sformatf("v%0d_retry", i), 32'(m_retry), 32'(vecs[i].retry));
      chk($sformatf("v%0d_sub", i), 32'(m_sub), 32'd7);
      chk($sformatf("v%0d_tx_left", i), 32'(exp_q.size()), 32'd0);
      repeat (3) step();
      chk($sformatf("v%0d_held", i), 32'({m_done, m_fail, m_lane}),
          32'({vecs[i].done, vecs[i].fail, vecs[i].lane}));
      stop_idle($sformatf("v%0d_idle", i));
    end
    wrong_end = 0;
    // No START_RESP: fail must rise exactly TIMEOUT_CYC cycles after WAIT_START entry
    sel = 0; err_all = '0; err_link = '0; skip_start = 1;
    exp_q.push_back(code(0, 0));
    en_a = 1;
    n = 0;
    while (!m_req && n < 20) begin step(); n++; end
    chk("tmo_req_seen", 32'(m_req), 32'd1);
    n = 0;
    while (!m_fail && n < 300) begin step(); n++; end
    chk("tmo_cycles", 32'(n), 32'd100);
    chk("tmo_state", 32'({m_done, m_fail, m_retry, m_sub}), 32'({1'b0, 1'b1, 2'd0, 3'd0}));
    chk("tmo_tx_left", 32'(exp_q.size()), 32'd0);
    skip_start = 0;
    stop_idle("tmo_idle");
    // enable_i dropped in WAIT_PAT during a retry pass, then restart clean
    sb_on = 0; err_all = 16'h0101; err_link = 16'h0101;
    en_a = 1;
    n = 0;
    while (!(m_retry == 2'd1 && m_pat) && n < 2000) begin step(); n++; end
    chk("abort_reach", 32'(n < 2000), 32'd1);
    step();
    en_a = 0; clear_pend();
    step();
    chk("abort_idle", 32'({m_done, m_fail, m_req, m_tx_v, m_pat, m_tx, m_lane, m_sub, m_retry}),
        32'({5'b0, 8'h00, 16'hFFFF, 3'd0, 2'd0}));
    err_all = '0; err_link = '0; sb_on = 1;
    push_pass(8'hFF);
    en_a = 1;
    wait_end("restart_finish", n);
    chk("restart_done", 32'({m_done, m_fail, m_retry, m_lane}), 32'({2'b10, 2'd0, 16'hFFFF}));
    chk("restart_tx_left", 32'(exp_q.size()), 32'd0);
    stop_idle("restart_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
